// File: rtl/fp_wire.sv
// Shared fp_unit operation encoding: one-hot operation select used on the execute interface.
package fp_wire;

    typedef struct packed {
        logic fmadd;
        logic fmsub;
        logic fnmadd;
        logic fnmsub;
        logic fadd;
        logic fsub;
        logic fmul;
        logic fdiv;
        logic fsqrt;
        logic fsgnj;
        logic fcmp;
        logic fmax;
        logic fclass;
        logic fcvt_f2i;
        logic fcvt_i2f;
        logic fmv_f2i;
        logic fmv_i2f;
    } fp_operation_type;

    localparam fp_operation_type init_fp_operation = '0;

endpackage

// File: rtl/fp_unit_arbiter.sv
// Two-port round-robin issue scheduler for the shared fp_unit; routes each fpu_ready
// back to the issuing port through an in-order tag FIFO and keeps fdiv/fsqrt isolated.
module fp_unit_arbiter
    import fp_wire::*;
#(
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [31:0]      req0_data1,
    input  logic [31:0]      req0_data2,
    input  logic [31:0]      req0_data3,
    input  logic [1:0]       req0_fmt,
    input  logic [2:0]       req0_rm,
    input  fp_operation_type req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [31:0]      req1_data1,
    input  logic [31:0]      req1_data2,
    input  logic [31:0]      req1_data3,
    input  logic [1:0]       req1_fmt,
    input  logic [2:0]       req1_rm,
    input  fp_operation_type req1_op,
    output logic [31:0]      fpu_data1,
    output logic [31:0]      fpu_data2,
    output logic [31:0]      fpu_data3,
    output logic [1:0]       fpu_fmt,
    output logic [2:0]       fpu_rm,
    output fp_operation_type fpu_op,
    output logic             fpu_enable,
    input  logic [31:0]      fpu_result,
    input  logic [4:0]       fpu_flags,
    input  logic             fpu_ready,
    output logic             rsp0_valid,
    output logic [31:0]      rsp0_result,
    output logic [4:0]       rsp0_flags,
    output logic             rsp1_valid,
    output logic [31:0]      rsp1_result,
    output logic [4:0]       rsp1_flags,
    output logic             err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, PIPE, DRAIN, ITER} state_t;

    state_t           r_state, w_state_nxt;
    logic [CW-1:0]    r_cnt, w_cnt_nxt;
    logic [PW-1:0]    r_wr, r_rd;
    logic             r_fifo [DEPTH];
    logic             r_prio;
    logic             r_err;
    logic             r_en;
    fp_operation_type r_op;
    logic [31:0]      r_data1, r_data2, r_data3;
    logic [1:0]       r_fmt;
    logic [2:0]       r_rm;

    logic w_iter0, w_iter1, w_pick0, w_pick1, w_open;
    logic w_cand, w_cand_vld, w_cand_iter;
    logic w_pop, w_head;
    logic w_rdy0, w_rdy1, w_gnt0, w_gnt1, w_issue;

    assign w_iter0     = req0_op.fdiv | req0_op.fsqrt;
    assign w_iter1     = req1_op.fdiv | req1_op.fsqrt;
    // A port's ready depends only on the other port's valid, never its own.
    assign w_pick0     = ~r_prio | ~req1_valid;
    assign w_pick1     = r_prio | ~req0_valid;
    assign w_open      = reset & (r_cnt < FULL);
    assign w_cand      = req1_valid & (~req0_valid | r_prio);
    assign w_cand_vld  = req0_valid | req1_valid;
    assign w_cand_iter = w_cand ? w_iter1 : w_iter0;
    assign w_pop       = reset & fpu_ready & (r_cnt != '0);
    assign w_head      = r_fifo[r_rd];

    always_comb begin
        w_state_nxt = r_state;
        w_rdy0      = 1'b0;
        w_rdy1      = 1'b0;
        case (r_state)
            IDLE: begin
                w_rdy0 = w_open & w_pick0;
                w_rdy1 = w_open & w_pick1;
            end
            PIPE: begin
                w_rdy0 = w_open & w_pick0 & ~w_iter0;
                w_rdy1 = w_open & w_pick1 & ~w_iter1;
            end
            default: ;
        endcase
        w_gnt0    = req0_valid & w_rdy0;
        w_gnt1    = req1_valid & w_rdy1;
        w_issue   = w_gnt0 | w_gnt1;
        w_cnt_nxt = r_cnt + CW'(w_issue) - CW'(w_pop);
        case (r_state)
            IDLE: begin
                if (w_issue)
                    w_state_nxt = (w_gnt1 ? w_iter1 : w_iter0) ? ITER : PIPE;
            end
            PIPE: begin
                if (!w_issue && w_cnt_nxt == '0)
                    w_state_nxt = IDLE;
                else if (w_cand_vld && w_cand_iter)
                    w_state_nxt = DRAIN;
            end
            DRAIN: begin
                if (w_cnt_nxt == '0)
                    w_state_nxt = IDLE;
            end
            ITER: begin
                if (w_pop)
                    w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_wr    <= '0;
            r_rd    <= '0;
            r_prio  <= 1'b0;
            r_err   <= 1'b0;
            r_en    <= 1'b0;
            r_op    <= init_fp_operation;
            r_data1 <= '0;
            r_data2 <= '0;
            r_data3 <= '0;
            r_fmt   <= '0;
            r_rm    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_err   <= r_err | (fpu_ready & (r_cnt == '0));
            r_en    <= w_issue;
            r_op    <= w_issue ? (w_gnt1 ? req1_op : req0_op) : init_fp_operation;
            if (w_gnt0)
                r_prio <= 1'b1;
            else if (w_gnt1)
                r_prio <= 1'b0;
            if (w_issue) begin
                r_fifo[r_wr] <= w_gnt1;
                r_wr    <= r_wr + PW'(1);
                r_data1 <= w_gnt1 ? req1_data1 : req0_data1;
                r_data2 <= w_gnt1 ? req1_data2 : req0_data2;
                r_data3 <= w_gnt1 ? req1_data3 : req0_data3;
                r_fmt   <= w_gnt1 ? req1_fmt : req0_fmt;
                r_rm    <= w_gnt1 ? req1_rm : req0_rm;
            end
            if (w_pop)
                r_rd <= r_rd + PW'(1);
        end
    end

    assign req0_ready  = w_rdy0;
    assign req1_ready  = w_rdy1;
    assign fpu_data1   = r_data1;
    assign fpu_data2   = r_data2;
    assign fpu_data3   = r_data3;
    assign fpu_fmt     = r_fmt;
    assign fpu_rm      = r_rm;
    assign fpu_op      = r_op;
    assign fpu_enable  = r_en;
    assign err         = r_err;

    // Responses are steered combinationally by the FIFO head tag.
    assign rsp0_valid  = w_pop & ~w_head;
    assign rsp1_valid  = w_pop & w_head;
    assign rsp0_result = rsp0_valid ? fpu_result : '0;
    assign rsp0_flags  = rsp0_valid ? fpu_flags : '0;
    assign rsp1_result = rsp1_valid ? fpu_result : '0;
    assign rsp1_flags  = rsp1_valid ? fpu_flags : '0;

endmodule

// File: tb/tb_fp_unit_arbiter.sv
// Directed bench for fp_unit_arbiter; the bench plays the fp_unit side by hand.
module tb_fp_unit_arbiter;
    import fp_wire::*;

    logic             clock = 1'b0;
    logic             reset;
    logic             req0_valid, req1_valid;
    logic             req0_ready, req1_ready;
    logic [31:0]      req0_data1, req0_data2, req0_data3;
    logic [31:0]      req1_data1, req1_data2, req1_data3;
    logic [1:0]       req0_fmt, req1_fmt;
    logic [2:0]       req0_rm, req1_rm;
    fp_operation_type req0_op, req1_op;
    logic [31:0]      fpu_data1, fpu_data2, fpu_data3;
    logic [1:0]       fpu_fmt;
    logic [2:0]       fpu_rm;
    fp_operation_type fpu_op;
    logic             fpu_enable;
    logic [31:0]      fpu_result;
    logic [4:0]       fpu_flags;
    logic             fpu_ready;
    logic             rsp0_valid, rsp1_valid;
    logic [31:0]      rsp0_result, rsp1_result;
    logic [4:0]       rsp0_flags, rsp1_flags;
    logic             err;

    int checks = 0;
    int errors = 0;
    fp_operation_type op_add, op_mul, op_div;

    fp_unit_arbiter #(.DEPTH(4)) dut (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_data1(req0_data1), .req0_data2(req0_data2), .req0_data3(req0_data3),
        .req0_fmt(req0_fmt), .req0_rm(req0_rm), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_data1(req1_data1), .req1_data2(req1_data2), .req1_data3(req1_data3),
        .req1_fmt(req1_fmt), .req1_rm(req1_rm), .req1_op(req1_op),
        .fpu_data1(fpu_data1), .fpu_data2(fpu_data2), .fpu_data3(fpu_data3),
        .fpu_fmt(fpu_fmt), .fpu_rm(fpu_rm), .fpu_op(fpu_op), .fpu_enable(fpu_enable),
        .fpu_result(fpu_result), .fpu_flags(fpu_flags), .fpu_ready(fpu_ready),
        .rsp0_valid(rsp0_valid), .rsp0_result(rsp0_result), .rsp0_flags(rsp0_flags),
        .rsp1_valid(rsp1_valid), .rsp1_result(rsp1_result), .rsp1_flags(rsp1_flags),
        .err(err)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_data1 = '0; req0_data2 = '0; req0_data3 = '0;
        req1_data1 = '0; req1_data2 = '0; req1_data3 = '0;
        req0_fmt = '0; req1_fmt = '0; req0_rm = '0; req1_rm = '0;
        req0_op = init_fp_operation; req1_op = init_fp_operation;
        fpu_result = '0; fpu_flags = '0; fpu_ready = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic set_req(input int port, input fp_operation_type op,
                           input logic [31:0] a, input logic [31:0] b);
        if (port == 0) begin
            req0_valid = 1'b1; req0_op = op; req0_data1 = a; req0_data2 = b; req0_rm = 3'd0;
        end else begin
            req1_valid = 1'b1; req1_op = op; req1_data1 = a; req1_data2 = b; req1_rm = 3'd0;
        end
    endtask

    initial begin
        op_add = init_fp_operation; op_add.fadd = 1'b1;
        op_mul = init_fp_operation; op_mul.fmul = 1'b1;
        op_div = init_fp_operation; op_div.fdiv = 1'b1;
        clear_inputs();
        reset = 1'b0;
        tick();
        tick();
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        chk1("rst_ready0", req0_ready, 1'b0);
        chk1("rst_ready1", req1_ready, 1'b0);
        chk1("rst_enable", fpu_enable, 1'b0);
        chk32("rst_op", 32'(fpu_op), 32'(init_fp_operation));
        chk32("rst_data1", fpu_data1, 32'h0);
        chk1("rst_err", err, 1'b0);
        chk1("rst_rsp0", rsp0_valid, 1'b0);
        clear_inputs();
        reset = 1'b1;

        // single add on port 0
        set_req(0, op_add, 32'h3F800000, 32'h40000000);
        #1;
        chk1("add_ready0", req0_ready, 1'b1);
        tick();
        req0_valid = 1'b0;
        chk1("add_enable", fpu_enable, 1'b1);
        chk32("add_data1", fpu_data1, 32'h3F800000);
        chk32("add_data2", fpu_data2, 32'h40000000);
        chk32("add_op", 32'(fpu_op), 32'(op_add));
        fpu_ready = 1'b1; fpu_result = 32'h40400000; fpu_flags = 5'h00;
        #1;
        chk1("add_rsp0_valid", rsp0_valid, 1'b1);
        chk32("add_rsp0_result", rsp0_result, 32'h40400000);
        chk32("add_rsp0_flags", 32'(rsp0_flags), 32'h0);
        chk1("add_rsp1_valid", rsp1_valid, 1'b0);
        tick();
        fpu_ready = 1'b0;
        chk1("add_enable_one_cycle", fpu_enable, 1'b0);
        chk32("add_op_idle", 32'(fpu_op), 32'(init_fp_operation));

        // alternating grants, responses returned the cycle after issue
        do_reset();
        set_req(0, op_mul, 32'h40000000, 32'h40400000);
        set_req(1, op_mul, 32'h40000000, 32'h40400000);
        for (int i = 0; i < 4; i++) begin
            fpu_ready = (i > 0); fpu_result = 32'h40C00000; fpu_flags = 5'h00;
            #1;
            chk1("alt_ready0", req0_ready, (i % 2) == 0);
            chk1("alt_ready1", req1_ready, (i % 2) == 1);
            if (i > 0) begin
                chk1("alt_rsp0_valid", rsp0_valid, ((i - 1) % 2) == 0);
                chk1("alt_rsp1_valid", rsp1_valid, ((i - 1) % 2) == 1);
                chk32("alt_result", rsp0_result | rsp1_result, 32'h40C00000);
            end
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        fpu_ready = 1'b1;
        #1;
        chk1("alt_last_rsp1", rsp1_valid, 1'b1);
        chk1("alt_last_rsp0", rsp0_valid, 1'b0);
        tick();
        fpu_ready = 1'b0;

        // full FIFO, no bypass on retire, then wrap-around drain
        do_reset();
        set_req(0, op_add, 32'h3F800000, 32'h3F800000);
        set_req(1, op_add, 32'h3F800000, 32'h3F800000);
        for (int i = 0; i < 4; i++) tick();
        #1;
        chk1("full_ready0", req0_ready, 1'b0);
        chk1("full_ready1", req1_ready, 1'b0);
        fpu_ready = 1'b1; fpu_result = 32'h40000000;
        #1;
        chk1("full_retire_rsp0", rsp0_valid, 1'b1);
        chk1("full_nobypass0", req0_ready, 1'b0);
        chk1("full_nobypass1", req1_ready, 1'b0);
        tick();
        fpu_ready = 1'b0;
        #1;
        chk1("full_regrant0", req0_ready, 1'b1);
        chk1("full_regrant1", req1_ready, 1'b0);
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            fpu_ready = 1'b1;
            #1;
            chk1("wrap_rsp1", rsp1_valid, (i % 2) == 0);
            chk1("wrap_rsp0", rsp0_valid, (i % 2) == 1);
            tick();
        end
        fpu_ready = 1'b0;

        // drain pipelined work before an iterative divide
        do_reset();
        set_req(0, op_add, 32'h3F800000, 32'h40000000);
        tick();
        tick();
        req0_valid = 1'b0;
        set_req(1, op_div, 32'h3F800000, 32'h40400000);
        #1;
        chk1("drain_no_grant_a", req1_ready, 1'b0);
        tick();
        fpu_ready = 1'b1; fpu_result = 32'h40400000;
        #1;
        chk1("drain_rsp0_a", rsp0_valid, 1'b1);
        chk1("drain_no_grant_b", req1_ready, 1'b0);
        tick();
        #1;
        chk1("drain_rsp0_b", rsp0_valid, 1'b1);
        chk1("drain_no_grant_c", req1_ready, 1'b0);
        tick();
        fpu_ready = 1'b0;
        #1;
        chk1("div_grant", req1_ready, 1'b1);
        tick();
        set_req(0, op_add, 32'h3F800000, 32'h40000000);
        chk1("div_enable", fpu_enable, 1'b1);
        chk32("div_op", 32'(fpu_op), 32'(op_div));
        chk32("div_data2", fpu_data2, 32'h40400000);
        #1;
        chk1("iter_ready0", req0_ready, 1'b0);
        chk1("iter_ready1", req1_ready, 1'b0);
        tick();
        fpu_ready = 1'b1; fpu_result = 32'h3EAAAAAB; fpu_flags = 5'h01;
        #1;
        chk1("div_rsp1_valid", rsp1_valid, 1'b1);
        chk32("div_rsp1_result", rsp1_result, 32'h3EAAAAAB);
        chk32("div_rsp1_flags", 32'(rsp1_flags), 32'h01);
        chk1("div_rsp0_valid", rsp0_valid, 1'b0);
        chk1("iter_ready0_at_retire", req0_ready, 1'b0);
        tick();
        clear_inputs();
        #1;
        chk1("post_iter_ready0", req0_ready, 1'b1);

        // spurious fpu_ready with nothing outstanding
        do_reset();
        fpu_ready = 1'b1; fpu_result = 32'h12345678;
        #1;
        chk1("spur_rsp0", rsp0_valid, 1'b0);
        chk1("spur_rsp1", rsp1_valid, 1'b0);
        tick();
        fpu_ready = 1'b0;
        chk1("spur_err_set", err, 1'b1);
        tick();
        chk1("spur_err_held", err, 1'b1);
        do_reset();
        chk1("spur_err_cleared", err, 1'b0);

        // reset with three ops in flight
        set_req(0, op_add, 32'h3F800000, 32'h3F800000);
        tick();
        tick();
        tick();
        clear_inputs();
        reset = 1'b0;
        req0_valid = 1'b1;
        tick();
        chk1("mid_rst_enable", fpu_enable, 1'b0);
        chk32("mid_rst_op", 32'(fpu_op), 32'(init_fp_operation));
        chk32("mid_rst_data1", fpu_data1, 32'h0);
        chk1("mid_rst_ready0", req0_ready, 1'b0);
        chk1("mid_rst_rsp0", rsp0_valid, 1'b0);
        clear_inputs();
        reset = 1'b1;
        set_req(1, op_add, 32'h3F800000, 32'h40000000);
        #1;
        chk1("fresh_ready1", req1_ready, 1'b1);
        tick();
        req1_valid = 1'b0;
        chk1("fresh_enable", fpu_enable, 1'b1);
        fpu_ready = 1'b1; fpu_result = 32'h40400000; fpu_flags = 5'h00;
        #1;
        chk1("fresh_rsp1_valid", rsp1_valid, 1'b1);
        chk32("fresh_rsp1_result", rsp1_result, 32'h40400000);
        chk1("fresh_rsp0_valid", rsp0_valid, 1'b0);
        tick();
        fpu_ready = 1'b0;
        chk1("fresh_err", err, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp_unit_arbiter.md
# fp_unit_arbiter

Two-port arbiter and issue scheduler in front of the shared single-precision `fp_unit`. It accepts operation requests from two requesters (port 0 and port 1) and grants them round-robin. It drives the `fp_unit` execute interface and routes each `ready` response back to the requester that issued the operation, using an in-order tag FIFO. It also serialises iterative operations (`fdiv`, `fsqrt`) against the pipelined ones, so `fp_unit` never holds mixed-latency work.

## Interface
- `DEPTH`, default 4: maximum number of pipelined operations in flight; this is also the tag FIFO depth (power of 2, ≥2).
- `clock` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-low.
- `req0_valid`, `req1_valid` input 1: request present on that port.
- `req0_ready`, `req1_ready` output 1: grant; the request is consumed in any cycle where valid and ready are both 1.
- `reqN_data1`, `reqN_data2`, `reqN_data3` input 32: operands.
- `reqN_fmt` input 2: format field, passed through unchanged.
- `reqN_rm` input 3: rounding mode, passed through unchanged.
- `reqN_op` input `fp_operation_type`: operation select (from `fp_wire`).
- `fpu_data1`, `fpu_data2`, `fpu_data3` output 32; `fpu_fmt` output 2; `fpu_rm` output 3; `fpu_op` output `fp_operation_type`; `fpu_enable` output 1: drive `fp_unit_i.fp_exe_i`.
- `fpu_result` input 32, `fpu_flags` input 5, `fpu_ready` input 1: from `fp_unit_o.fp_exe_o`.
- `rsp0_valid`, `rsp1_valid` output 1: a response is present for that port; no backpressure.
- `rspN_result` output 32, `rspN_flags` output 5: response data, valid while `rspN_valid` is 1.
- `err` output 1: sticky protocol error.

## Operation
- **Classes.** An operation is iterative when `op.fdiv | op.fsqrt`. Every other non-zero op is pipelined.
- **Counter.** `cnt`, range 0..`DEPTH`, holds the number of issued, unretired ops. Tag FIFO entries are 1 bit (the port ID).
- **FSM states:**
  - `IDLE`: `cnt` == 0.
  - `PIPE`: pipelined ops outstanding.
  - `DRAIN`: the granted candidate is iterative while `cnt` > 0; no grant is given.
  - `ITER`: one iterative op outstanding; no grant is given.
- **FSM transitions:**
  - `IDLE` → `PIPE` on a pipelined issue.
  - `IDLE` → `ITER` on an iterative issue.
  - `PIPE` → `DRAIN` when the candidate is iterative.
  - `PIPE` → `IDLE` when `cnt` reaches 0 with no issue.
  - `DRAIN` → `IDLE` when `cnt` reaches 0; the iterative op is granted from `IDLE` on the next cycle.
  - `ITER` → `IDLE` on `fpu_ready`.
- **Grant eligibility.** A grant is allowed only in `IDLE` or `PIPE`, with `cnt` < `DEPTH`, and, in `PIPE`, only when the candidate is pipelined.
- **No bypass when full.** When `cnt` == `DEPTH`, no grant is given, even if a retire happens in the same cycle.
- **Round-robin.** `prio` resets to 0. With both ports valid, grant the `prio` port; after any grant, set `prio` to the non-granted port. With a single port valid, grant that port if eligible.
- **Candidate.** The candidate is the port that round-robin would select.
- **ready/valid independence.** `reqN_ready` is 1 only for the selected eligible port and does not depend on `reqN_valid` of the same port.
- **Issue.** On grant, register the operands, `fmt`, `rm`, and `op` into the `fpu_*` outputs, set `fpu_enable` to 1 for exactly one cycle, and push the port ID. When there is no issue, `fpu_enable` is 0 and `fpu_op` is `init_fp_operation`.
- **Retire.** On `fpu_ready`, pop the FIFO head and drive that port's `rspN_valid`, `rspN_result`, and `rspN_flags` combinationally. The other port's `rsp` outputs are 0.
- **Simultaneous issue and retire.** Push and pop occur together and `cnt` is unchanged.
- **Wrap-around.** FIFO read and write pointers are log2(`DEPTH`) bits and wrap modulo `DEPTH`.
- **Error.** `fpu_ready` while `cnt` == 0 sets `err`; the response is dropped and `cnt` stays 0. `err` clears only on reset.

## Timing
- Reset (`reset` == 0 at an edge): `cnt` = 0, FIFO pointers = 0, `prio` = 0, state `IDLE`, `err` = 0. All `fpu_*` outputs are 0 and `fpu_op` is `init_fp_operation`. `req*_ready`, `rsp*_valid`, and `rsp*` data are all 0.
- Reset mid-operation: outstanding tags are discarded. Requesters and `fp_unit` share `reset`, so no stale `fpu_ready` arrives.
- Grant to `fpu_enable`: 1 cycle (registered).
- `fpu_ready` to `rspN_valid`: 0 cycles (combinational).
- Throughput: one pipelined issue per cycle while `cnt` < `DEPTH`.
- Iterative op: the next grant comes no earlier than the cycle after its `fpu_ready`.
- `DRAIN` entry: the cycle the iterative candidate is seen. Exit: the cycle after `cnt` reaches 0.

## Test plan
- **Single add:** port 0 sends fadd `3F800000` + `40000000`, rm = 0. Expect `fpu_enable` 1 cycle after grant, then `rsp0_valid` with `40400000`, flags `00`, and `rsp1_valid` = 0.
- **Alternating grants:** both ports continuously send fmul `40000000` × `40400000`. Expect grants to alternate 0,1,0,1 starting with 0, and every response is `40C00000` delivered to the issuing port in issue order.
- **Full FIFO:** hold `fpu_ready` low and issue 4 ops. Expect `req*_ready` = 0 while `cnt` == 4. One `fpu_ready` retires port 0's op and a new grant is given on the following cycle.
- **Drain then divide:** 2 fadds are in flight and port 1 requests fdiv `3F800000` / `40400000`, rm = 0. Expect no grant until both fadds retire, then the grant from `IDLE`. Expect `rsp1` = `3EAAAAAB`, flags `01`, and no grants while in `ITER`.
- **Spurious ready:** pulse `fpu_ready` with `cnt` == 0. Expect `err` = 1 and held, both `rsp*_valid` = 0, and `err` = 0 only after reset.
- **Reset mid-operation:** assert reset with 3 ops in flight. Expect every output at its reset value, and after release, a fresh fadd returns its correct result on the correct port.
